// File: rtl/click_sync_pkg.sv
// Shared definitions for the clocked-to-click transmitter and its helpers:
// FSM state encoding and width helpers for pointers, counts and hold timers.
package click_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2
  } tx_state_e;

  // Pointer width for a power-of-2 buffer: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width able to hold an occupancy value from 0 to depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a down-counter loaded with hold_cycles.
  function automatic int hold_w(input int hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Brings a 2-phase toggle from an asynchronous domain into clk and turns
// each transition into a single-cycle registered event pulse.
module toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tgl,
  output logic o_evt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   evt_q,  evt_d;

  // Shift the raw toggle through the chain and compare the last stage with its delayed copy.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_tgl};
    prev_d = sync_q[SYNC_STAGES-1];
    evt_d  = sync_q[SYNC_STAGES-1] ^ prev_q;
  end

  // Synchronizer, history and event flops; all clear to 0 to match the reset toggle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      evt_q  <= evt_d;
    end
  end

  assign o_evt = evt_q;

endmodule

// File: rtl/sync_click_tx.sv
// Clocked transmitter into a click pipeline. Words accepted on a valid/ready
// port are buffered, then launched one at a time: data is set up on o_data,
// held for HOLD_CYCLES, then o_drive toggles. The returning i_free toggle is
// synchronized and retires the token before the next one may launch.
module sync_click_tx
  import click_sync_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pmt,
  output logic                       o_drive,
  output logic [DATA_W-1:0]          o_data,
  input  logic                       i_free,
  output logic                       o_done,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_err
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int IDX_W  = PTR_W - 1;
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam int HOLD_W = hold_w(HOLD_CYCLES);

  // ---------------------------------------------------------------------------
  // Input buffer
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  occ_s;
  logic [IDX_W-1:0]  wr_idx_s, rd_idx_s;
  logic              full_s, empty_s;
  logic              push_s, pop_s;
  logic              free_evt_s;

  assign wr_idx_s = wr_ptr_q[IDX_W-1:0];
  assign rd_idx_s = rd_ptr_q[IDX_W-1:0];
  assign full_s   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx_s == rd_idx_s);
  assign empty_s  = (wr_ptr_q == rd_ptr_q);
  assign occ_s    = wr_ptr_q - rd_ptr_q;

  // Ready is held low while in reset so nothing is accepted into a flushed buffer.
  assign o_ready  = rst & ~full_s;
  assign push_s   = i_valid & o_ready;
  assign o_count  = CNT_W'(occ_s);

  // Advance the pointers on push/pop; a simultaneous push and pop leaves occupancy unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Buffer pointers; reset flushes the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Buffer storage; cleared on reset so no stale word can ever reach o_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_idx_s] <= i_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Returning free toggle
  // ---------------------------------------------------------------------------
  toggle_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_free_sync (
    .clk   (clk),
    .rst   (rst),
    .i_tgl (i_free),
    .o_evt (free_evt_s)
  );

  // ---------------------------------------------------------------------------
  // Launch / retire FSM
  // ---------------------------------------------------------------------------
  tx_state_e         state_q, state_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic              drive_q, drive_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;

  // Next-state logic: pop and set up in IDLE, count the hold then toggle in
  // SETUP, and retire on the free event in WAIT (chaining straight into the
  // next token when one is buffered and permitted).
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    drive_d = drive_q;
    data_d  = data_q;
    done_d  = 1'b0;
    pop_s   = 1'b0;
    if (free_evt_s && (state_q != ST_WAIT)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (!empty_s && i_pmt) begin
          pop_s   = 1'b1;
          data_d  = mem_q[rd_idx_s];
          hold_d  = HOLD_W'(HOLD_CYCLES);
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (hold_q == HOLD_W'(1)) begin
          drive_d = ~drive_q;
          state_d = ST_WAIT;
        end else begin
          hold_d  = hold_q - HOLD_W'(1);
        end
      end
      ST_WAIT: begin
        if (free_evt_s) begin
          done_d = 1'b1;
          if (!empty_s && i_pmt) begin
            pop_s   = 1'b1;
            data_d  = mem_q[rd_idx_s];
            hold_d  = HOLD_W'(HOLD_CYCLES);
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; reset abandons any token in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      drive_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      drive_q <= drive_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_drive = drive_q;
  assign o_data  = data_q;
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_sync_click_tx.sv
// Self-checking bench for sync_click_tx: a scoreboard queue of launched words
// compared at every o_drive toggle, a table of buffer-fill vectors, and
// hand-written sequences for latency, permission, spurious free and reset.
module tb_sync_click_tx;

  localparam int DATA_W      = 32;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HOLD_CYCLES = 1;
  localparam int CNT_W       = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              i_pmt;
  logic              o_drive;
  logic [DATA_W-1:0] o_data;
  logic              i_free;
  logic              o_done;
  logic [CNT_W-1:0]  o_count;
  logic              o_err;

  logic free_auto   = 1'b0;
  logic free_manual = 1'b0;
  logic auto_en     = 1'b0;
  assign i_free = free_auto ^ free_manual;

  sync_click_tx #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_pmt   (i_pmt),
    .o_drive (o_drive),
    .o_data  (o_data),
    .i_free  (i_free),
    .o_done  (o_done),
    .o_count (o_count),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          errors   = 0;
  logic [31:0] exp_q[$];
  int          tog_cnt  = 0;
  int          done_cnt = 0;
  logic        drive_prev  = 1'b0;
  logic        outstanding = 1'b0;
  int          fcnt = 0;

  typedef struct {
    logic [31:0]      data;
    logic             exp_ready;
    logic [CNT_W-1:0] exp_count;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    i_valid = 1'b1;
    i_data  = d;
    if (o_ready) begin
      exp_q.push_back(d);
      step();
    end else begin
      check("push_accept", {63'd0, o_ready}, 64'd1);
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    check("done_timeout", done_cnt, target);
  endtask

  // Monitor: scoreboard compare on every drive toggle, token accounting, and
  // an optional responder that returns a free toggle a few cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        drive_prev  = o_drive;
        outstanding = 1'b0;
        fcnt        = 0;
        free_auto   = 1'b0;
      end else begin
        if (o_done) begin
          done_cnt++;
          check("done_with_token", {63'd0, outstanding}, 64'd1);
          outstanding = 1'b0;
        end
        if (o_drive !== drive_prev) begin
          tog_cnt++;
          check("one_outstanding", {63'd0, outstanding}, 64'd0);
          outstanding = 1'b1;
          if (exp_q.size() == 0) begin
            check("token_queue_nonempty", 64'(exp_q.size()), 64'd1);
          end else begin
            check("token_data", o_data, exp_q.pop_front());
          end
          drive_prev = o_drive;
          if (auto_en) fcnt = 3;
        end
        if (fcnt > 0) begin
          fcnt--;
          if (fcnt == 0) free_auto = ~free_auto;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int d0;

    vecs[0] = '{32'h1000_0001, 1'b1, 3'd1};
    vecs[1] = '{32'h2000_0002, 1'b1, 3'd2};
    vecs[2] = '{32'h3000_0003, 1'b1, 3'd3};
    vecs[3] = '{32'h4000_0004, 1'b1, 3'd4};
    vecs[4] = '{32'h5000_0005, 1'b0, 3'd4};

    // 1: reset with valid held high
    rst = 1'b0; i_valid = 1'b1; i_data = 32'hDEAD_BEEF; i_pmt = 1'b1;
    repeat (3) step();
    check("rst_ready", {63'd0, o_ready}, 64'd0);
    check("rst_drive", {63'd0, o_drive}, 64'd0);
    check("rst_data",  o_data, 64'd0);
    check("rst_count", o_count, 64'd0);
    check("rst_done",  {63'd0, o_done}, 64'd0);
    check("rst_err",   {63'd0, o_err}, 64'd0);
    rst = 1'b1; i_valid = 1'b0;
    step();
    check("post_rst_ready", {63'd0, o_ready}, 64'd1);
    check("post_rst_count", o_count, 64'd0);

    // 2: single token latency and free->done timing
    push_word(32'hA5A5_0001);
    check("t2_count_e0", o_count, 64'd1);
    check("t2_data_e0",  o_data, 64'd0);
    step();
    check("t2_data_e1",  o_data, 64'hA5A5_0001);
    check("t2_drive_e1", {63'd0, o_drive}, 64'd0);
    check("t2_count_e1", o_count, 64'd0);
    step();
    check("t2_drive_e2", {63'd0, o_drive}, 64'd1);
    free_manual = ~free_manual;
    repeat (3) step();
    check("t2_done_early", {63'd0, o_done}, 64'd0);
    step();
    check("t2_done_pulse", {63'd0, o_done}, 64'd1);
    step();
    check("t2_done_single", {63'd0, o_done}, 64'd0);
    check("t2_err", {63'd0, o_err}, 64'd0);

    // 3: permission gating then in-order launch
    i_pmt = 1'b0;
    t0 = tog_cnt; d0 = done_cnt;
    push_word(32'h0000_0011);
    push_word(32'h0000_0022);
    repeat (20) step();
    check("t3_no_launch", tog_cnt, t0);
    check("t3_count", o_count, 64'd2);
    auto_en = 1'b1;
    i_pmt   = 1'b1;
    wait_done(d0 + 2, 200);
    check("t3_toggles", tog_cnt, t0 + 2);
    check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // 4: fill to full from the table, then drain
    i_pmt = 1'b0;
    d0 = done_cnt;
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      i_data  = vecs[k].data;
      check("t4_ready", {63'd0, o_ready}, {63'd0, vecs[k].exp_ready});
      if (vecs[k].exp_ready) exp_q.push_back(vecs[k].data);
      step();
      check("t4_count", o_count, {61'd0, vecs[k].exp_count});
    end
    check("t4_full_ready", {63'd0, o_ready}, 64'd0);
    i_pmt = 1'b1;
    step();
    check("t4_ready_after_pop", {63'd0, o_ready}, 64'd1);
    check("t4_count_after_pop", o_count, 64'd3);
    exp_q.push_back(vecs[4].data);
    step();
    i_valid = 1'b0;
    check("t4_count_fifth", o_count, 64'd4);
    wait_done(d0 + 5, 400);
    check("t4_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t4_count_end", o_count, 64'd0);

    // 5: spurious free in IDLE
    check("t5_err_before", {63'd0, o_err}, 64'd0);
    t0 = tog_cnt; d0 = done_cnt;
    free_manual = ~free_manual;
    repeat (6) step();
    check("t5_err_set", {63'd0, o_err}, 64'd1);
    check("t5_no_toggle", tog_cnt, t0);
    check("t5_no_done", done_cnt, d0);
    repeat (5) step();
    check("t5_err_sticky", {63'd0, o_err}, 64'd1);
    push_word(32'h5555_AAAA);
    wait_done(d0 + 1, 100);
    check("t5_err_still", {63'd0, o_err}, 64'd1);

    // 6: reset while a token is outstanding and two words are buffered
    auto_en = 1'b0;
    t0 = tog_cnt;
    push_word(32'h6000_0001);
    push_word(32'h6000_0002);
    push_word(32'h6000_0003);
    for (int n = 0; n < 20 && tog_cnt == t0; n++) step();
    check("t6_launched", tog_cnt, t0 + 1);
    check("t6_buffered", o_count, 64'd2);
    rst = 1'b0;
    exp_q.delete();
    free_manual = 1'b0;
    d0 = done_cnt;
    step();
    check("t6_drive", {63'd0, o_drive}, 64'd0);
    check("t6_data",  o_data, 64'd0);
    check("t6_count", o_count, 64'd0);
    check("t6_ready", {63'd0, o_ready}, 64'd0);
    check("t6_done",  {63'd0, o_done}, 64'd0);
    check("t6_err",   {63'd0, o_err}, 64'd0);
    rst = 1'b1;
    step();
    check("t6_ready_rel", {63'd0, o_ready}, 64'd1);
    repeat (8) step();
    check("t6_no_done", done_cnt, d0);
    check("t6_idle_drive", {63'd0, o_drive}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
